sonar_scan_scheduler: RTL
=========================

// Module: sonar_scan_scheduler
// PURPOSE
//  Time-shares the three ultrasonic rangefinders (forward, right, left) so only one pings at a time,
//  avoiding acoustic crosstalk. Round-robin F->R->L: fires a trigger pulse, times the echo, stores a
//  distance per sensor, flags timeouts. Feeds the obstacle/turn decision and motor sequencing logic.
// PARAMETERS
//  TRIG_CYCLES    1000       trigger pulse width in clk cycles (10 us @ 100 MHz)
//  TIMEOUT_CYCLES 2500000    max wait for echo rise, and max echo width (25 ms)
//  GAP_CYCLES     6000000    quiet time after each ping before the next sensor fires (60 ms)
//  OBST_THRESH    58000      forward obstacle threshold in echo cycles (~10 cm)
//  CNT_W          22         counter/distance width; TIMEOUT_CYCLES must be < 2**CNT_W
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  enable     in   1      1 = keep scanning; 0 = stop after current ping
//  echoF      in   1      forward echo (asynchronous)
//  echoR      in   1      right echo (asynchronous)
//  echoL      in   1      left echo (asynchronous)
//  sigF       out  1      forward trigger
//  sigR       out  1      right trigger
//  sigL       out  1      left trigger
//  disF       out  CNT_W  last forward echo width in cycles
//  disR       out  CNT_W  last right echo width
//  disL       out  CNT_W  last left echo width
//  dis_valid  out  1      1-cycle pulse: a dis* register was just written
//  dis_sel    out  2      sensor written on dis_valid: 0=F, 1=R, 2=L
//  timeout    out  3      sticky per sensor {L,R,F}: last ping timed out
//  obstacle   out  1      registered: disF < OBST_THRESH and timeout[0]==0
// BEHAVIOUR
//  - Clock and reset: single clk domain; reset is synchronous and active-high.
//  - Reset values: sig* = 0, dis* = 0, dis_valid = 0, dis_sel = 0, timeout = 0, obstacle = 0.
//    FSM goes to IDLE and the sensor pointer goes to F.
//  - Reset asserted mid-ping: sig* are 0 on the next edge. The partial measurement is discarded.
//  - Echo inputs: each passes through a 2-FF synchronizer. Edge detect runs on the synced value.
//    Echo latency to FSM is therefore 2 cycles. Only the selected sensor's echo is observed.
//  - FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
//    IDLE: if enable=1, go to TRIG on the next cycle, clear cnt.
//    TRIG: selected sig* is high for exactly TRIG_CYCLES cycles, then WAIT_RISE with cnt=0.
//          Only one sig* is ever high at a time.
//    WAIT_RISE: synced echo rise -> MEASURE with cnt=1.
//          If cnt reaches TIMEOUT_CYCLES first, record a timeout and go to GAP.
//    MEASURE: cnt increments while synced echo=1. Synced fall -> write dis[sel]=cnt, go to GAP.
//          If cnt reaches TIMEOUT_CYCLES, record a timeout and go to GAP.
//    GAP: wait GAP_CYCLES cycles, then advance the pointer F->R->L->F.
//          Then TRIG if enable=1, else IDLE.
//  - Writing a result: the write occurs on the transition edge out of WAIT_RISE/MEASURE.
//    dis_valid=1 and dis_sel=pointer in the following cycle, for exactly one cycle.
//  - Timeout write: dis[sel] = {CNT_W{1'b1}} and timeout[sel] = 1.
//    A normal write clears timeout[sel].
//  - Counter: saturates at TIMEOUT_CYCLES and never wraps.
//    dis* hold their value between writes.
//  - obstacle: updated the cycle after disF is written. No change on R/L writes.
//  - enable dropped mid-ping: the ping completes, including GAP, then the FSM goes to IDLE.
//    The pointer advances as normal. enable re-asserted in IDLE resumes at the next sensor.
//  - Echo already high on entry to WAIT_RISE (stale): no rise is seen, so it resolves to a timeout.
//  - Echo glitch shorter than the synchronizer: no requirement beyond no lock-up.
// TESTING  (TRIG_CYCLES=4, TIMEOUT_CYCLES=64, GAP_CYCLES=16, OBST_THRESH=20, CNT_W=8)
//  1. reset, enable=1, model echoF high 30 cycles after sigF falls
//     -> sigF high exactly 4 cycles; disF=30; dis_valid 1 cycle with dis_sel=0; obstacle=0.
//  2. three full pings with echo widths F=10, R=40, L=25
//     -> triggers fire in order F,R,L,F, never overlapping, >=16 idle cycles between.
//     -> disF=10, disR=40, disL=25; obstacle=1.
//  3. echoR never rises -> after 64 cycles disR=8'hFF, timeout=3'b010, dis_valid with dis_sel=1.
//     -> the next successful R ping clears timeout[1].
//  4. echoL stuck high for 200 cycles -> disL=8'hFF, timeout[2]=1. The scheduler proceeds to F.
//  5. enable dropped during MEASURE of R -> R result written, GAP completes, FSM idles.
//     -> re-enable resumes with sigL first.
//  6. reset pulsed while sigF is high -> sigF=0 next cycle, all outputs at reset values.
//     -> with enable=1 the scan restarts at F.

Source files
------------

// File: rtl/sonar_scan_scheduler.sv
// Round-robin ping scheduler for the forward/right/left ultrasonic rangefinders.
// One sensor pings at a time; echo widths and timeouts are latched per sensor.
`timescale 1ns/1ps

// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | stopped, waiting for enable
// S_TRIG     | trigger pulse high on the selected sensor
// S_WAIT_RISE| waiting for the synced echo to rise (bounded)
// S_MEASURE  | counting echo-high cycles (bounded)
// S_GAP      | acoustic quiet time before moving to the next sensor
module sonar_scan_scheduler #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int GAP_CYCLES     = 6000000,
    parameter int OBST_THRESH    = 58000,
    parameter int CNT_W          = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             echoF,
    input  logic             echoR,
    input  logic             echoL,
    output logic             sigF,
    output logic             sigR,
    output logic             sigL,
    output logic [CNT_W-1:0] disF,
    output logic [CNT_W-1:0] disR,
    output logic [CNT_W-1:0] disL,
    output logic             dis_valid,
    output logic [1:0]       dis_sel,
    output logic [2:0]       timeout,
    output logic             obstacle
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    localparam int TMR_MAX = (GAP_CYCLES > TRIG_CYCLES) ? GAP_CYCLES : TRIG_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TRIG_LOAD = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] OBST_LIM  = CNT_W'(OBST_THRESH);

    logic [2:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       ptr_next;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sig_q;

    logic [2:0]       echo_meta;
    logic [2:0]       echo_sync;
    logic [2:0]       echo_prev;
    logic             sel_echo;
    logic             sel_prev;
    logic             echo_rise;
    logic             echo_fall;
    logic             cnt_tc;
    logic             wr_ok;
    logic             wr_tmo;
    logic [CNT_W-1:0] wr_val;

    function automatic logic [2:0] sensor_onehot(input logic [1:0] p);
        case (p)
            2'd0:    sensor_onehot = 3'b001;
            2'd1:    sensor_onehot = 3'b010;
            2'd2:    sensor_onehot = 3'b100;
            default: sensor_onehot = 3'b000;
        endcase
    endfunction

    // Echoes are asynchronous; edge detection only ever looks at synced values.
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_meta <= '0;
            echo_sync <= '0;
            echo_prev <= '0;
        end else begin
            echo_meta <= {echoL, echoR, echoF};
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
        end
    end

    always_comb begin
        sel_echo = 1'b0;
        sel_prev = 1'b0;
        case (ptr)
            2'd0: begin
                sel_echo = echo_sync[0];
                sel_prev = echo_prev[0];
            end
            2'd1: begin
                sel_echo = echo_sync[1];
                sel_prev = echo_prev[1];
            end
            2'd2: begin
                sel_echo = echo_sync[2];
                sel_prev = echo_prev[2];
            end
            default: begin
                sel_echo = 1'b0;
                sel_prev = 1'b0;
            end
        endcase
        echo_rise = sel_echo & ~sel_prev;
        echo_fall = ~sel_echo & sel_prev;
        ptr_next  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        cnt_tc    = (cnt >= CNT_LIMIT);
        // An edge arriving on the limit cycle still wins over the timeout.
        wr_ok     = (state == S_MEASURE) && echo_fall;
        wr_tmo    = cnt_tc && (((state == S_WAIT_RISE) && !echo_rise) ||
                               ((state == S_MEASURE) && !echo_fall));
        wr_val    = wr_tmo ? {CNT_W{1'b1}} : cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ptr   <= 2'd0;
            tmr   <= '0;
            cnt   <= '0;
            sig_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_TRIG;
                        tmr   <= TRIG_LOAD;
                        cnt   <= '0;
                        sig_q <= sensor_onehot(ptr);
                    end
                end
                S_TRIG: begin
                    if (tmr == '0) begin
                        state <= S_WAIT_RISE;
                        cnt   <= '0;
                        sig_q <= '0;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                S_WAIT_RISE: begin
                    if (echo_rise) begin
                        state <= S_MEASURE;
                        cnt   <= CNT_ONE;
                    end else if (cnt_tc) begin
                        state <= S_GAP;
                        tmr   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    if (echo_fall || cnt_tc) begin
                        state <= S_GAP;
                        tmr   <= GAP_LOAD;
                    end else if (sel_echo) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (tmr == '0) begin
                        ptr <= ptr_next;
                        if (enable) begin
                            state <= S_TRIG;
                            tmr   <= TRIG_LOAD;
                            cnt   <= '0;
                            sig_q <= sensor_onehot(ptr_next);
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    sig_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disF      <= '0;
            disR      <= '0;
            disL      <= '0;
            dis_valid <= 1'b0;
            dis_sel   <= 2'd0;
            timeout   <= '0;
            obstacle  <= 1'b0;
        end else begin
            dis_valid <= wr_ok | wr_tmo;
            if (wr_ok || wr_tmo) begin
                dis_sel <= ptr;
                case (ptr)
                    2'd0: begin
                        disF       <= wr_val;
                        timeout[0] <= wr_tmo;
                    end
                    2'd1: begin
                        disR       <= wr_val;
                        timeout[1] <= wr_tmo;
                    end
                    2'd2: begin
                        disL       <= wr_val;
                        timeout[2] <= wr_tmo;
                    end
                    default: begin
                        disF <= disF;
                    end
                endcase
            end
            // Evaluated one cycle after a forward write so it sees the new disF.
            if (dis_valid && (dis_sel == 2'd0)) begin
                obstacle <= (disF < OBST_LIM) && !timeout[0];
            end
        end
    end

    assign sigF = sig_q[0];
    assign sigR = sig_q[1];
    assign sigL = sig_q[2];

endmodule
